// File: rtl/adm_decoder.sv
// adm_decoder: adaptive delta-modulation decoder, one signed sample per accepted bit.
// Optional leaky integrator under macro ADM_LEAK_EN.  Rev 1.0
`default_nettype none

module adm_decoder #(
  parameter int OUT_W      = 9,
  parameter int STEP_INIT  = 20,
  parameter int STEP_MIN   = 5,
  parameter int STEP_MAX   = 160,
  parameter int RUN_LEN    = 3,
  parameter int LEAK_SHIFT = 4
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic [OUT_W-1:0] result,
  output logic             result_valid,
  output logic [OUT_W-1:0] step,
  output logic             sat_flag
);

  localparam int RC_W = $clog2(RUN_LEN + 1);
  localparam logic [RC_W-1:0]           RUN_SAT  = RC_W'(RUN_LEN);
  localparam logic [RC_W-1:0]           RUN_ONE  = RC_W'(1);
  localparam logic [OUT_W-1:0]          STEP_RST = OUT_W'(STEP_INIT);
  localparam logic [OUT_W-1:0]          STEP_LO  = OUT_W'(STEP_MIN);
  localparam logic [OUT_W:0]            STEP_HI  = (OUT_W+1)'(STEP_MAX);
  localparam logic signed [OUT_W+1:0]   RES_MAX  = (OUT_W+2)'(2**(OUT_W-1) - 1);
  localparam logic signed [OUT_W+1:0]   RES_MIN  = -RES_MAX - 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             accept;
  logic             w_unused_state;

  logic [OUT_W-1:0] result_q, result_d;
  logic [OUT_W-1:0] step_q, step_d;
  logic [RC_W-1:0]  run_q, run_d;
  logic             prev_q, prev_d;
  logic             hist_q, hist_d;
  logic             sat_q, sat_d;
  logic             valid_q, valid_d;

  logic [OUT_W:0]          w_dbl;
  logic [OUT_W-1:0]        w_half;
  logic signed [OUT_W+1:0] w_base;
  logic signed [OUT_W+1:0] w_sum;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = start ? S_ACTIVE : S_IDLE;
  end

  always_comb begin
    bit_ready = start & ~reset;
    accept    = bit_valid & bit_ready;
  end

  // Mode is visible only through bit_ready; the register is kept for its reset value.
  assign w_unused_state = state_q[0];

  assign w_dbl  = {step_q, 1'b0};
  assign w_half = step_q >> 1;

  always_comb begin
    result_d = result_q;
    step_d   = step_q;
    run_d    = run_q;
    prev_d   = prev_q;
    hist_d   = hist_q;
    sat_d    = sat_q;
    valid_d  = 1'b0;
    w_base   = '0;
    w_sum    = '0;
    if (accept) begin
      valid_d = 1'b1;
      hist_d  = 1'b1;
      prev_d  = bit_in;
      if (!hist_q) begin
        run_d = RUN_ONE;
      end else if (bit_in == prev_q) begin
        run_d = (run_q >= RUN_SAT) ? RUN_SAT : run_q + RUN_ONE;
        if (run_d == RUN_SAT)
          step_d = (w_dbl > STEP_HI) ? STEP_HI[OUT_W-1:0] : w_dbl[OUT_W-1:0];
      end else begin
        run_d  = RUN_ONE;
        step_d = (w_half < STEP_LO) ? STEP_LO : w_half;
      end

      w_base = {{2{result_q[OUT_W-1]}}, result_q};
`ifdef ADM_LEAK_EN
      w_base = w_base - (w_base >>> LEAK_SHIFT);
`endif
      if (bit_in) w_sum = w_base + $signed({2'b00, step_d});
      else        w_sum = w_base - $signed({2'b00, step_d});

      if (w_sum > RES_MAX) begin
        result_d = RES_MAX[OUT_W-1:0];
        sat_d    = 1'b1;
      end else if (w_sum < RES_MIN) begin
        result_d = RES_MIN[OUT_W-1:0];
        sat_d    = 1'b1;
      end else begin
        result_d = w_sum[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      result_q <= '0;
      step_q   <= STEP_RST;
      run_q    <= '0;
      prev_q   <= 1'b0;
      hist_q   <= 1'b0;
      sat_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      step_q   <= step_d;
      run_q    <= run_d;
      prev_q   <= prev_d;
      hist_q   <= hist_d;
      sat_q    <= sat_d;
      valid_q  <= valid_d;
    end
  end

  assign result       = result_q;
  assign step         = step_q;
  assign sat_flag     = sat_q;
  assign result_valid = valid_q;

endmodule

`default_nettype wire

// File: doc/adm_decoder.md
Name: adm_decoder

Overview:
- Parametrised adaptive delta-modulation (CVSD-style) decoder.
- Consumes a 1-bit encoded stream and reconstructs a signed sample per accepted bit.
- Successor to the fixed-step decoder: configurable width, step size and bounds, with run-length step adaptation, saturation, a valid/ready handshake and a sticky saturation flag.
- Sits between the bit-stream source and the sample sink (DAC/PWM or capture buffer).

Parameters:
- OUT_W, 9, width of signed result and of internal step register.
- STEP_INIT, 20, step value after reset.
- STEP_MIN, 5, lower clamp for step; must be >=1.
- STEP_MAX, 160, upper clamp for step; must be <= 2^(OUT_W-1)-1.
- RUN_LEN, 3, number of consecutive identical bits (including current) that triggers step doubling; must be >=2.
- LEAK_SHIFT, 4, leak divisor exponent; only used with ADM_LEAK_EN.

Ports:
- CLK100MHZ  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- start  input  1  decoder enable; 0 = IDLE, hold all state.
- bit_valid  input  1  encode bit present on bit_in.
- bit_in  input  1  encoded bit; 1 = increment, 0 = decrement.
- bit_ready  output  1  combinational, equals start & ~reset.
- result  output  OUT_W  signed reconstructed sample (registered).
- result_valid  output  1  one-cycle pulse, one cycle after each accepted bit.
- step  output  OUT_W  current step value (registered, unsigned).
- sat_flag  output  1  sticky; set when any update clamped; cleared only by reset.

Behaviour:
- **Clock and reset:** single clock and reset domain. Reset is synchronous and active-high; all state is updated on the rising edge of CLK100MHZ.
- **Reset values:** result=0, result_valid=0, step=STEP_INIT, sat_flag=0, run_cnt=0, prev_bit=0, hist_valid=0, state=IDLE. Reset overrides everything, including mid-stream; the next accepted bit is treated as first.
- **States:**
  - IDLE: start=0; no accepts, all registers hold, result_valid=0.
  - ACTIVE: start=1.
  - IDLE<->ACTIVE follows start each cycle. Leaving ACTIVE does not clear history.
- **Accept:** bit_valid & bit_ready on a clock edge. Exactly one update per accept; result_valid=1 on the following cycle, otherwise 0.
- **Step adaptation** (computed first; new step used for the same update):
  - First bit (hist_valid=0): run_cnt=1; step unchanged; hist_valid=1.
  - bit_in==prev_bit: run_cnt=min(run_cnt+1, RUN_LEN). If the new run_cnt==RUN_LEN, step=min(2*step, STEP_MAX). Run_cnt stays saturated, so each further equal bit doubles again.
  - bit_in!=prev_bit: run_cnt=1; step=max(step>>1, STEP_MIN).
  - prev_bit<=bit_in.
- **Accumulate:** sum = result + step_next (bit 1) or result - step_next (bit 0).
  - Compute in OUT_W+2 bits signed.
  - Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; for defaults that is [-256, 255].
  - Any clamp sets sat_flag.
- **Latency:** 1 cycle from accept to result/step/result_valid update.
- **Overflow:** no wrap-around anywhere; step doubling is computed wide before clamping.

Optional Feature:
- Macro ADM_LEAK_EN.
- **Defined:** leaky integrator. Sum becomes result - (result >>> LEAK_SHIFT) ± step_next, followed by the same saturation. The arithmetic shift rounds toward -inf. Leak is applied only on accepted bits, never in IDLE.
- **Undefined:** pure integrator as specified above; LEAK_SHIFT is unused.

Test Plan:
- **Positive ramp:** reset, start=1, bits 1,1,1,1,1 -> result 20,40,80,160,255. Step 20,20,40,80,160. sat_flag=1 after 5th. result_valid pulses once per bit.
- **Negative ramp:** reset, bits 0,0,0,0,0 -> result -20,-40,-80,-160,-256. sat_flag=1 after 5th.
- **Alternating bits:** reset, bits 1,0,1,0 -> result 20,10,15,10. Step 20,10,5,5; STEP_MIN holds.
- **Stall and IDLE:** start=0 with bit_valid=1 for 5 cycles -> bit_ready=0, no result_valid, result/step unchanged. Raise start with bit 1 from result=40, step=20, run_cnt=2 -> step 40, result 80.
- **Reset mid-stream:** after bits 1,1,1 (result 80, step 40), assert reset one cycle, then bit 0 -> result -20, step 20, sat_flag=0.
- **ADM_LEAK_EN:** defined, reset, bits 1,1 -> result 20, then 39 (20 - 1 + 20).
